// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and width helper for the BCD-to-binary converter.
package bcd_pkg;

  localparam int         BCD_DIGIT_W     = 4;
  localparam logic [3:0] BCD_CORR        = 4'd3;
  localparam logic [3:0] BCD_CORR_THRESH = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  // Smallest binary width able to hold 10**digits - 1.
  function automatic int bin_width(input int digits);
    longint p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return $clog2(p);
  endfunction

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// Request/result handshake bundle for the BCD-to-binary converter.
interface bcd_to_binary_seq_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);

  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_bcd;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_W-1:0]      out_bin;
  logic                  out_err;
  logic                  busy;

  // Requester / result consumer side.
  modport master (
    output in_valid, in_bcd, out_ready,
    input  in_ready, out_valid, out_bin, out_err, busy
  );

  // Converter side.
  modport slave (
    input  in_valid, in_bcd, out_ready,
    output in_ready, out_valid, out_bin, out_err, busy
  );

endinterface

// File: rtl/bcd_digit_sub3.sv
// Per-digit correction of reverse double-dabble: digits >= 8 get 3 subtracted.
module bcd_digit_sub3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  assign dout = (din >= BCD_CORR_THRESH) ? (din - BCD_CORR) : din;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter: one shift-and-correct step per clock,
// valid/ready handshake on request and result sides.
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_to_binary_seq_if.slave bus
);

  localparam int               SR_W     = BCD_DIGIT_W * DIGITS;
  localparam int               CNT_W    = $clog2(SR_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SR_W - 1);

  if (DIGITS < 1 || DIGITS > 5) begin : g_bad_digits
    $error("bcd_to_binary_seq: DIGITS must be in 1..5");
  end
  if (BIN_W < bin_width(DIGITS) || BIN_W > SR_W) begin : g_bad_width
    $error("bcd_to_binary_seq: BIN_W must be between ceil(log2(10**DIGITS)) and 4*DIGITS");
  end

  // True when any nibble of the word is not a decimal digit.
  function automatic logic has_bad_digit(input logic [SR_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  bcd_state_t       state, state_nxt;
  logic [SR_W-1:0]  bcd_sr, bin_sr;
  logic [SR_W-1:0]  bcd_shifted, bcd_corrected, bin_shifted;
  logic [CNT_W-1:0] cnt;
  logic             err_q;
  logic             accept;

  assign accept = (state == IDLE) && bus.in_valid;

  // The BCD register's LSB falls into the binary register's MSB each step.
  assign bcd_shifted = {1'b0, bcd_sr[SR_W-1:1]};
  assign bin_shifted = {bcd_sr[0], bin_sr[SR_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_sub3 u_sub3 (
      .din  (bcd_shifted[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (bcd_corrected[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept in IDLE, run SR_W shift steps, hold result until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)     state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_LAST)  state_nxt = DONE;
      DONE:    if (bus.out_ready)    state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // Handshake and result outputs decoded from state.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.busy      = (state == SHIFT);
    bus.out_valid = (state == DONE);
    bus.out_err   = (state == DONE) && err_q;
    // For valid input the bits of bin_sr above BIN_W are zero.
    bus.out_bin   = ((state == DONE) && !err_q) ? bin_sr[BIN_W-1:0] : '0;
  end

  // Shift registers, step counter and error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd_sr <= '0;
      bin_sr <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bcd_sr <= bus.in_bcd;
            bin_sr <= '0;
            cnt    <= '0;
            err_q  <= has_bad_digit(bus.in_bcd);
          end
        end
        SHIFT: begin
          bcd_sr <= bcd_corrected;
          bin_sr <= bin_shifted;
          cnt    <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Scoreboard bench for bcd_to_binary_seq: the driver pushes expected results on
// accept, the monitor pops and compares whenever a result is handed over.
module tb_bcd_to_binary_seq;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int LAT    = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bcd_to_binary_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic             err;
    int               acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   rmode  = 1'b0;
  logic rfix   = 1'b1;
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Result-side driver and monitor: out_ready is set for the coming edge, then
  // a handshake on that edge is scored.
  always @(negedge clk) begin
    bus.out_ready = rmode ? 1'($urandom_range(0, 1)) : rfix;
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (bus.out_valid === 1'b1 && !prev_ov) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: out_valid rose with nothing outstanding, out_bin=%0d", bus.out_bin);
        end else begin
          chk("latency", cyc - sb[0].acc, LAT);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready && sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("out_bin", 32'(bus.out_bin), 32'(mon_e.bin));
        chk("out_err", 32'(bus.out_err), 32'(mon_e.err));
      end
      prev_ov = bus.out_valid;
    end
  end

  task automatic send(input logic [4*DIGITS-1:0] bcd, input logic [BIN_W-1:0] eb,
                      input logic ee, input bit track);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_bcd   = bcd;
    while (bus.in_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed low for %0d cycles, required 1", n);
      bus.in_valid = 1'b0;
      return;
    end
    if (track) begin
      e.bin = eb;
      e.err = ee;
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_ov(input int lim);
    int n;
    n = 0;
    while (n < lim) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) break;
      n++;
    end
    if (n >= lim) begin
      checks++;
      errors++;
      $display("FAIL wait_out_valid: out_valid=0 after %0d cycles, required 1", lim);
    end
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while (sb.size() > 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("drain_outstanding", sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, outstanding=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_bcd   = '0;

    // Reset held for three clocks
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_bin",   bus.out_bin,   0);
    chk("rst_out_err",   bus.out_err,   0);
    chk("rst_in_ready",  bus.in_ready,  1);
    chk("rst_busy",      bus.busy,      0);
    rst_n = 1'b1;

    // Directed conversions
    send(16'h1234, 14'd1234, 1'b0, 1'b1);
    chk("shift_busy",     bus.busy,     1);
    chk("shift_in_ready", bus.in_ready, 0);
    send(16'h9999, 14'd9999, 1'b0, 1'b1);
    send(16'h0000, 14'd0,    1'b0, 1'b1);
    send(16'h12A4, 14'd0,    1'b1, 1'b1);
    send(16'h0001, 14'd1,    1'b0, 1'b1);
    send(16'h8000, 14'd8000, 1'b0, 1'b1);
    send(16'hF000, 14'd0,    1'b1, 1'b1);
    drain(200);

    // Backpressure in DONE with a competing request
    @(posedge clk);
    #1 rfix = 1'b0;
    send(16'h0815, 14'd815, 1'b0, 1'b1);
    wait_ov(40);
    bus.in_valid = 1'b1;
    bus.in_bcd   = 16'h5555;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_out_bin",   bus.out_bin,   815);
      chk("bp_in_ready",  bus.in_ready,  0);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rfix = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready",  bus.in_ready,  1);
    chk("bp_release_out_valid", bus.out_valid, 0);
    send(16'h5555, 14'd5555, 1'b0, 1'b1);
    drain(200);

    // Reset in the middle of a conversion
    send(16'h0777, 14'd0, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_in_ready",  bus.in_ready,  1);
    chk("abort_busy",      bus.busy,      0);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("abort_no_result", bus.out_valid, 0);
    send(16'h0042, 14'd42, 1'b0, 1'b1);
    drain(200);

    // Back-to-back sweep with random result backpressure
    @(posedge clk);
    #1 rmode = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      int v;
      v = (i * 7919) % 10000;
      send(to_bcd(v), BIN_W'(v), 1'b0, 1'b1);
    end
    send(to_bcd(9999), 14'd9999, 1'b0, 1'b1);
    drain(500);
    @(posedge clk);
    #1 rmode = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
